cla8_addsub_pipe: RTL and testbench

- 2-stage pipelined 8-bit carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- It is the complement of the combinational CLA datapath: the add path is reused and a subtract path is added, plus status flags.
- It is the registered arithmetic unit between the operand source (register file or sequencer) and the result sink in the CLA datapath.
- Stage 1 computes the low 4-bit group (bits 3:0) and its group carry. Stage 2 computes the high group (bits 7:4) and the flags.

---
 rtl/cla8_addsub_pipe_if.sv | 31 +++
 rtl/cla8_addsub_pipe.sv | 152 +++++++++++++++
 tb/tb_cla8_addsub_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla8_addsub_pipe_if.sv
// Purpose : operand/result bundle for the pipelined CLA adder/subtractor.
// Signals : in_valid/in_ready/a/b/op_sub/cin    operand beat (source -> unit)
//           out_valid/out_ready/sum/cb_out/ovf/zero/neg   result beat (unit -> sink)
// Modports: master = operand source + result sink side, slave = arithmetic unit side.
interface cla8_addsub_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op_sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cb_out;
   logic             ovf;
   logic             zero;
   logic             neg;

   modport master (
      output in_valid, a, b, op_sub, cin, out_ready,
      input  in_ready, out_valid, sum, cb_out, ovf, zero, neg
   );

   modport slave (
      input  in_valid, a, b, op_sub, cin, out_ready,
      output in_ready, out_valid, sum, cb_out, ovf, zero, neg
   );
endinterface

// File: rtl/cla8_addsub_pipe.sv
// Purpose : 2-stage pipelined carry-lookahead adder/subtractor with
//           valid/ready on both sides. Stage 1 resolves the low group and
//           its group carry, stage 2 the high group plus status flags.
// Ports   : clk     rising-edge clock
//           rst     synchronous active-high reset (drops all in-flight beats)
//           io_bus  slave side of cla8_addsub_pipe_if (operands in, result out)
module cla8_addsub_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned GROUP = 4
) (
   input logic                clk,
   input logic                rst,
   cla8_addsub_pipe_if.slave  io_bus
);

   if (WIDTH != 2 * GROUP) begin : g_bad_cfg
      $error("cla8_addsub_pipe: WIDTH must equal 2*GROUP");
   end

   // Flat lookahead carries for one group: every c[i+1] is a sum of
   // generate terms and the propagated group carry-in, no ripple.
   function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] p,
                                                input logic [GROUP-1:0] g,
                                                input logic             c0);
      logic [GROUP:0] c;
      logic           term;
      c    = '0;
      c[0] = c0;
      for (int i = 0; i < int'(GROUP); i++) begin
         term = c0;
         for (int k = 0; k <= i; k++) term = term & p[k];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            c[i+1] = c[i+1] | term;
         end
      end
      return c;
   endfunction

   // Pipeline occupancy and handshakes
   logic r_valid1;
   logic r_valid2;
   logic w_in_ready;
   logic w_in_fire;
   logic w_adv2;

   assign w_in_ready = !r_valid1 || !r_valid2 || io_bus.out_ready;
   assign w_in_fire  = io_bus.in_valid && w_in_ready;
   assign w_adv2     = r_valid1 && (!r_valid2 || io_bus.out_ready);

   // Stage 1: operand conditioning and low group
   logic [WIDTH-1:0] w_bp;
   logic             w_c0;
   logic [GROUP-1:0] w_p_lo;
   logic [GROUP-1:0] w_g_lo;
   logic [GROUP:0]   w_c_lo;
   logic [GROUP-1:0] w_sum_lo;

   // Subtract is A + ~B + ~borrow_in on the shared add path.
   assign w_bp     = io_bus.op_sub ? ~io_bus.b : io_bus.b;
   assign w_c0     = io_bus.op_sub ? ~io_bus.cin : io_bus.cin;
   assign w_p_lo   = io_bus.a[GROUP-1:0] ^ w_bp[GROUP-1:0];
   assign w_g_lo   = io_bus.a[GROUP-1:0] & w_bp[GROUP-1:0];
   assign w_c_lo   = lookahead(w_p_lo, w_g_lo, w_c0);
   assign w_sum_lo = w_p_lo ^ w_c_lo[GROUP-1:0];

   logic [GROUP-1:0] r_sum_lo;
   logic             r_c_grp;
   logic [GROUP-1:0] r_a_hi;
   logic [GROUP-1:0] r_bp_hi;
   logic             r_sub;

   // Stage 2: high group and flags
   logic [GROUP-1:0] w_p_hi;
   logic [GROUP-1:0] w_g_hi;
   logic [GROUP:0]   w_c_hi;
   logic [GROUP-1:0] w_sum_hi;
   logic [WIDTH-1:0] w_sum;
   logic             w_cb;
   logic             w_ovf;

   assign w_p_hi   = r_a_hi ^ r_bp_hi;
   assign w_g_hi   = r_a_hi & r_bp_hi;
   assign w_c_hi   = lookahead(w_p_hi, w_g_hi, r_c_grp);
   assign w_sum_hi = w_p_hi ^ w_c_hi[GROUP-1:0];
   assign w_sum    = {w_sum_hi, r_sum_lo};
   // Carry-out reads as borrow (inverted) when subtracting.
   assign w_cb     = r_sub ? ~w_c_hi[GROUP] : w_c_hi[GROUP];
   assign w_ovf    = (r_a_hi[GROUP-1] == r_bp_hi[GROUP-1]) &&
                     (w_sum_hi[GROUP-1] != r_a_hi[GROUP-1]);

   logic [WIDTH-1:0] r_sum;
   logic             r_cb;
   logic             r_ovf;
   logic             r_zero;
   logic             r_neg;

   // Valid bits depend only on handshakes, never on operand values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid1 <= 1'b0;
         r_valid2 <= 1'b0;
      end else begin
         if (w_in_fire)             r_valid1 <= 1'b1;
         else if (w_adv2)           r_valid1 <= 1'b0;
         if (w_adv2)                r_valid2 <= 1'b1;
         else if (io_bus.out_ready) r_valid2 <= 1'b0;
      end
   end

   // Stage data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum_lo <= '0;
         r_c_grp  <= 1'b0;
         r_a_hi   <= '0;
         r_bp_hi  <= '0;
         r_sub    <= 1'b0;
         r_sum    <= '0;
         r_cb     <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
      end else begin
         if (w_in_fire) begin
            r_sum_lo <= w_sum_lo;
            r_c_grp  <= w_c_lo[GROUP];
            r_a_hi   <= io_bus.a[WIDTH-1:WIDTH-GROUP];
            r_bp_hi  <= w_bp[WIDTH-1:WIDTH-GROUP];
            r_sub    <= io_bus.op_sub;
         end
         if (w_adv2) begin
            r_sum  <= w_sum;
            r_cb   <= w_cb;
            r_ovf  <= w_ovf;
            r_zero <= (w_sum == '0);
            r_neg  <= w_sum[WIDTH-1];
         end
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = r_valid2;
   assign io_bus.sum       = r_sum;
   assign io_bus.cb_out    = r_cb;
   assign io_bus.ovf       = r_ovf;
   assign io_bus.zero      = r_zero;
   assign io_bus.neg       = r_neg;

endmodule

// File: tb/tb_cla8_addsub_pipe.sv
// Purpose : self-checking bench for cla8_addsub_pipe. Expected results come
//           from integer arithmetic and an in-order queue of accepted beats.
// Ports   : none (top-level bench).
module tb_cla8_addsub_pipe;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cla8_addsub_pipe_if #(.WIDTH(8)) bus ();

   cla8_addsub_pipe #(.WIDTH(8), .GROUP(4)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   typedef struct {
      logic [7:0] sum;
      logic       cb;
      logic       ovf;
      logic       zero;
      logic       neg;
      int         age;
   } beat_t;

   beat_t q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   logic  exp_in_ready;
   logic  exp_out_valid;
   logic  in_fire;
   logic  out_fire;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Plain integer arithmetic: result, borrow/carry and signed range test.
   function automatic beat_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                       input logic sub, input logic cin);
      beat_t r;
      int    ures;
      int    sres;
      if (!sub) begin
         ures = int'(a) + int'(b) + int'(cin);
         sres = int'($signed(a)) + int'($signed(b)) + int'(cin);
         r.cb = (ures > 255);
      end else begin
         ures = int'(a) - int'(b) - int'(cin);
         sres = int'($signed(a)) - int'($signed(b)) - int'(cin);
         r.cb = (ures < 0);
      end
      r.sum  = 8'(ures);
      r.ovf  = (sres > 127) || (sres < -128);
      r.zero = (r.sum == 8'h00);
      r.neg  = r.sum[7];
      r.age  = 0;
      return r;
   endfunction

   // Before the edge: compare DUT against the model and decide handshakes.
   task automatic neg_phase();
      @(negedge clk);
      exp_in_ready  = (q.size() < 2) || bus.out_ready;
      exp_out_valid = (q.size() > 0) && (q[0].age >= 2);
      check("in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
      check("out_valid", 32'(bus.out_valid), 32'(exp_out_valid));
      if (exp_out_valid) begin
         check("sum", 32'(bus.sum), 32'(q[0].sum));
         check("cb_out", 32'(bus.cb_out), 32'(q[0].cb));
         check("ovf", 32'(bus.ovf), 32'(q[0].ovf));
         check("zero", 32'(bus.zero), 32'(q[0].zero));
         check("neg", 32'(bus.neg), 32'(q[0].neg));
      end
      in_fire  = bus.in_valid && exp_in_ready && !rst;
      out_fire = exp_out_valid && bus.out_ready && !rst;
   endtask

   // At the edge: advance the model, then leave #1 for new stimulus.
   task automatic pos_phase();
      beat_t nb;
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (out_fire) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (in_fire) begin
            nb     = ref_model(bus.a, bus.b, bus.op_sub, bus.cin);
            nb.age = 1;
            q.push_back(nb);
         end
      end
      #1;
   endtask

   task automatic cycle();
      neg_phase();
      pos_phase();
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic cin);
      bus.in_valid = v;
      bus.a        = a;
      bus.b        = b;
      bus.op_sub   = sub;
      bus.cin      = cin;
   endtask

   // One beat into an empty pipe; result must show exactly 2 cycles later.
   task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input logic cin, input logic [7:0] es,
                           input logic ecb, input logic eovf, input logic ezero,
                           input logic eneg);
      bus.out_ready = 1'b1;
      drive(1'b1, a, b, sub, cin);
      neg_phase();
      check({tag, "_acc"}, 32'(bus.in_ready), 32'd1);
      pos_phase();
      bus.in_valid = 1'b0;
      neg_phase();
      check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
      pos_phase();
      neg_phase();
      check({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_sum"}, 32'(bus.sum), 32'(es));
      check({tag, "_cb"}, 32'(bus.cb_out), 32'(ecb));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
      check({tag, "_zero"}, 32'(bus.zero), 32'(ezero));
      check({tag, "_neg"}, 32'(bus.neg), 32'(eneg));
      pos_phase();
   endtask

   initial begin
      logic hold;
      rst           = 1'b1;
      bus.out_ready = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_sum", 32'(bus.sum), 32'd0);
      check("rst_cb", 32'(bus.cb_out), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_zero", 32'(bus.zero), 32'd0);
      check("rst_neg", 32'(bus.neg), 32'd0);
      @(posedge clk);
      #1;

      // Directed arithmetic corners
      directed("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
      directed("add_carry", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      directed("sub_borrow",8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
      directed("sub_ovf",   8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
      directed("sub_bin",   8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Backpressure: two beats fill the pipe, third waits for release
      bus.out_ready = 1'b0;
      drive(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
      neg_phase(); check("bp_acc1", 32'(bus.in_ready), 32'd1); pos_phase();
      drive(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
      neg_phase(); check("bp_acc2", 32'(bus.in_ready), 32'd1); pos_phase();
      drive(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
      neg_phase(); check("bp_full", 32'(bus.in_ready), 32'd0);
      check("bp_hold_sum", 32'(bus.sum), 32'h02); pos_phase();
      neg_phase(); check("bp_full2", 32'(bus.in_ready), 32'd0);
      check("bp_hold_sum2", 32'(bus.sum), 32'h02); pos_phase();
      bus.out_ready = 1'b1;
      neg_phase(); check("bp_rel_ready", 32'(bus.in_ready), 32'd1);
      check("bp_out1", 32'(bus.sum), 32'h02); pos_phase();
      bus.in_valid = 1'b0;
      neg_phase(); check("bp_out2_v", 32'(bus.out_valid), 32'd1);
      check("bp_out2", 32'(bus.sum), 32'h04); pos_phase();
      neg_phase(); check("bp_out3_v", 32'(bus.out_valid), 32'd1);
      check("bp_out3", 32'(bus.sum), 32'h06); pos_phase();
      cycle();

      // Mid-operation reset drops both in-flight beats
      bus.out_ready = 1'b0;
      drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0); cycle();
      drive(1'b1, 8'h33, 8'h44, 1'b0, 1'b0); cycle();
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      neg_phase(); check("mr_pre_valid", 32'(bus.out_valid), 32'd1); pos_phase();
      rst = 1'b0;
      neg_phase();
      check("mr_out_valid", 32'(bus.out_valid), 32'd0);
      check("mr_in_ready", 32'(bus.in_ready), 32'd1);
      pos_phase();
      bus.out_ready = 1'b1;
      repeat (3) begin
         neg_phase(); check("mr_no_ghost", 32'(bus.out_valid), 32'd0); pos_phase();
      end
      directed("mr_fresh", 8'h20, 8'h22, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic with random stalls; source holds unaccepted beats
      hold = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (!hold) begin
            if ($urandom_range(0, 3) != 0)
               drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            else
               drive(1'b0, 8'hxx, 8'hxx, 1'bx, 1'bx);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         neg_phase();
         hold = bus.in_valid && !in_fire;
         pos_phase();
      end

      // Drain and confirm every accepted beat came out
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) cycle();
      check("drain_empty", 32'(q.size()), 32'd0);
      neg_phase(); check("drain_out_valid", 32'(bus.out_valid), 32'd0); pos_phase();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
